// File: rtl/counter_threebit_pkg.sv
// Shared types and constants for the 3-bit counter family.
package counter_threebit_pkg;

    localparam int unsigned CNT_W = 3;

    typedef logic [CNT_W-1:0] cnt_t;

    // Terminal value reached by the free-run wrap from zero.
    localparam cnt_t CNT_MAX  = CNT_W'(7);
    localparam cnt_t CNT_ZERO = CNT_W'(0);
    // Subtrahend for a single decrement step.
    localparam cnt_t DEC_STEP = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_t;

    // Packs the per-bit load inputs into a count word.
    function automatic cnt_t pack_bits(input logic b2, input logic b1, input logic b0);
        return {b2, b1, b0};
    endfunction

endpackage

// File: rtl/counter_down_3bit_if.sv
// Control, load and status signals of the 3-bit down counter.
interface counter_down_3bit_if;

    logic load;
    logic en;
    logic oneshot;
    logic d2;
    logic d1;
    logic d0;
    logic q2;
    logic q1;
    logic q0;
    logic bout;
    logic busy;
    logic done;

    // Controller side: drives strobes and load value, observes count/status.
    modport master (
        output load, en, oneshot, d2, d1, d0,
        input  q2, q1, q0, bout, busy, done
    );

    // Counter side.
    modport slave (
        input  load, en, oneshot, d2, d1, d0,
        output q2, q1, q0, bout, busy, done
    );

endinterface

// File: rtl/subtractor_3bit.sv
// Bit-level 3-bit ripple-borrow subtractor: {d2,d1,d0} = {a2,a1,a0} - {b2,b1,b0}.
module subtractor_3bit (
    input  logic a2,
    input  logic a1,
    input  logic a0,
    input  logic b2,
    input  logic b1,
    input  logic b0,
    output logic d2,
    output logic d1,
    output logic d0,
    output logic bout
);

    logic br0;
    logic br1;

    // Stage 0 has no borrow-in.
    assign d0  = a0 ^ b0;
    assign br0 = ~a0 & b0;

    // Stage 1: full subtractor cell.
    assign d1  = a1 ^ b1 ^ br0;
    assign br1 = (~a1 & b1) | (~(a1 ^ b1) & br0);

    // Stage 2: borrow-out of the MSB leaves the block.
    assign d2   = a2 ^ b2 ^ br1;
    assign bout = (~a2 & b2) | (~(a2 ^ b2) & br1);

endmodule

// File: rtl/counter_down_3bit.sv
// Loadable 3-bit down counter with free-run/one-shot modes and registered borrow pulse.
module counter_down_3bit
    import counter_threebit_pkg::*;
#(
    parameter cnt_t INIT_VALUE = 3'd0
) (
    input logic               clk,
    input logic               rst,
    counter_down_3bit_if.slave bus
);

    cnt_state_t state;
    cnt_state_t state_nxt;
    cnt_t       count;
    cnt_t       count_nxt;
    logic       oneshot_mode;
    logic       oneshot_mode_nxt;
    logic       bout_r;
    logic       bout_nxt;
    logic       busy_r;
    logic       busy_nxt;
    logic       done_r;
    logic       done_nxt;

    cnt_t       load_value;
    cnt_t       dec_value;
    logic       dec_borrow;

    assign load_value = pack_bits(bus.d2, bus.d1, bus.d0);

    // Single decrement datapath shared by all counting cases.
    subtractor_3bit u_dec (
        .a2   (count[2]),
        .a1   (count[1]),
        .a0   (count[0]),
        .b2   (DEC_STEP[2]),
        .b1   (DEC_STEP[1]),
        .b0   (DEC_STEP[0]),
        .d2   (dec_value[2]),
        .d1   (dec_value[1]),
        .d0   (dec_value[0]),
        .bout (dec_borrow)
    );

    // State, count, mode and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= INIT_VALUE;
            oneshot_mode <= 1'b0;
            bout_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            oneshot_mode <= oneshot_mode_nxt;
            bout_r       <= bout_nxt;
            busy_r       <= busy_nxt;
            done_r       <= done_nxt;
        end
    end

    // Next state and count: load beats enable; zero either wraps or terminates.
    always_comb begin
        state_nxt        = state;
        count_nxt        = count;
        oneshot_mode_nxt = oneshot_mode;
        bout_nxt         = 1'b0;

        if (bus.load) begin
            state_nxt        = RUN;
            count_nxt        = load_value;
            oneshot_mode_nxt = bus.oneshot;
        end else begin
            case (state)
                RUN: begin
                    if (bus.en) begin
                        if (count != CNT_ZERO) begin
                            count_nxt = dec_value;
                        end else if (!oneshot_mode) begin
                            count_nxt = dec_value;
                            bout_nxt  = dec_borrow;
                        end else begin
                            state_nxt = DONE;
                        end
                    end
                end
                IDLE:    state_nxt = IDLE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Status decode of the upcoming state and drive of the registered outputs.
    always_comb begin
        busy_nxt = (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);
        bus.q2   = count[2];
        bus.q1   = count[1];
        bus.q0   = count[0];
        bus.bout = bout_r;
        bus.busy = busy_r;
        bus.done = done_r;
    end

endmodule

// File: tb/tb_counter_down_3bit.sv
// Randomized scoreboard bench for counter_down_3bit against an arithmetic reference model.
module tb_counter_down_3bit;

    localparam logic [2:0] INIT = 3'd0;

    typedef struct {
        logic [2:0] q;
        logic       bout;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk;
    logic rst;
    counter_down_3bit_if bus ();

    counter_down_3bit #(.INIT_VALUE(INIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: plain integer count and a named phase.
    int   m_q       = 0;
    int   m_phase   = 0;   // 0 idle, 1 counting, 2 finished
    bit   m_oneshot = 1'b0;
    bit   m_bout    = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // Apply one cycle of inputs, advance the model, queue the expected response.
    task automatic step(input bit r, input bit l, input bit e, input bit o, input logic [2:0] dv);
        exp_t x;
        @(negedge clk);
        rst         = r;
        bus.load    = l;
        bus.en      = e;
        bus.oneshot = o;
        bus.d2      = dv[2];
        bus.d1      = dv[1];
        bus.d0      = dv[0];
        @(posedge clk);
        #1;
        m_bout = 1'b0;
        if (r) begin
            m_q = int'(INIT); m_phase = 0; m_oneshot = 1'b0;
        end else if (l) begin
            m_q = int'(dv); m_phase = 1; m_oneshot = o;
        end else if (m_phase == 1 && e) begin
            if (m_q > 0) m_q = m_q - 1;
            else if (!m_oneshot) begin m_q = 7; m_bout = 1'b1; end
            else m_phase = 2;
        end
        x.q    = 3'(m_q);
        x.bout = m_bout;
        x.busy = (m_phase == 1);
        x.done = (m_phase == 2);
        sb.push_back(x);
    endtask

    // Monitor: every cycle the DUT presents a new registered output.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("q",    int'({bus.q2, bus.q1, bus.q0}), int'(e.q));
            check("bout", int'(bus.bout), int'(e.bout));
            check("busy", int'(bus.busy), int'(e.busy));
            check("done", int'(bus.done), int'(e.done));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; bus.load = 1'b0; bus.en = 1'b0; bus.oneshot = 1'b0;
        bus.d2 = 1'b0; bus.d1 = 1'b0; bus.d0 = 1'b0;

        // Reset for two cycles, then enable pulses in IDLE.
        step(1, 0, 0, 0, 3'd0);
        step(1, 0, 0, 0, 3'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 3'd0);

        // Free-run wrap from 2.
        step(0, 1, 0, 0, 3'd2);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 3'd0);

        // One-shot from 3, with extra enables after DONE.
        step(0, 1, 0, 1, 3'd3);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 3'd0);

        // Load and enable on the same edge.
        step(0, 1, 0, 0, 3'd5);
        step(0, 1, 1, 0, 3'd6);

        // Enable gaps from 4.
        step(0, 1, 0, 0, 3'd4);
        step(0, 0, 1, 0, 3'd0);
        step(0, 0, 0, 0, 3'd0);
        step(0, 0, 0, 0, 3'd0);
        step(0, 0, 1, 0, 3'd0);

        // Reset mid-count at 5 with load/en asserted, then in DONE, then restart.
        step(0, 1, 0, 0, 3'd7);
        step(0, 0, 1, 0, 3'd0);
        step(0, 0, 1, 0, 3'd0);
        step(1, 1, 1, 0, 3'd3);
        step(0, 1, 0, 1, 3'd0);
        step(0, 0, 1, 0, 3'd0);
        step(0, 0, 1, 0, 3'd0);
        step(1, 0, 1, 0, 3'd0);
        step(0, 1, 0, 0, 3'd3);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 3'd0);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            bit r, l, e, o;
            logic [2:0] dv;
            r  = ($urandom_range(0, 31) == 0);
            l  = ($urandom_range(0, 5) == 0);
            e  = ($urandom_range(0, 3) != 0);
            o  = 1'($urandom_range(0, 1));
            dv = 3'($urandom_range(0, 7));
            step(r, l, e, o, dv);
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
